// File: rtl/ms_pkg.sv
// Shared types and helpers for the minesweeper mine-field generator.
package ms_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        DONE
    } ms_gen_state_t;

    localparam int REJ_W = 16;

    // Flat bitmap index of board cell (x,y) on a board w columns wide.
    function automatic int unsigned idx(input int unsigned x, input int unsigned y,
                                        input int unsigned w);
        return y * w + x;
    endfunction

endpackage

// File: rtl/ms_coord_filter.sv
// Combinational accept/reject decision for one random coordinate sample.
// Macro MS_SAFE_ZONE_EN widens the safe region from one cell to its clipped 3x3 neighbourhood.
module ms_coord_filter #(
    parameter int W  = 8,
    parameter int H  = 8,
    parameter int XW = $clog2(W),
    parameter int YW = $clog2(H),
    parameter int IW = $clog2(W * H)
) (
    input  logic [XW+YW-1:0] rand_xy,
    input  logic [XW-1:0]    safe_x,
    input  logic [YW-1:0]    safe_y,
    input  logic [W*H-1:0]   mine,
    output logic             accept,
    output logic [IW-1:0]    idx
);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          in_range;
    logic          safe_on_board;
    logic          occupied;
    logic          in_safe;
    int unsigned   flat;
`ifdef MS_SAFE_ZONE_EN
    int            dx;
    int            dy;
`endif

    always_comb begin
        x        = rand_xy[XW-1:0];
        y        = rand_xy[XW+YW-1:XW];
        in_range = (32'(x) < W) && (32'(y) < H);
        flat     = ms_pkg::idx(32'(x), 32'(y), W);
        idx      = in_range ? IW'(flat) : '0;
        occupied = in_range && mine[idx];
        // An off-board first click protects no board cell at all.
        safe_on_board = (32'(safe_x) < W) && (32'(safe_y) < H);
`ifdef MS_SAFE_ZONE_EN
        dx      = int'(32'(x)) - int'(32'(safe_x));
        dy      = int'(32'(y)) - int'(32'(safe_y));
        in_safe = safe_on_board && (dx >= -1) && (dx <= 1) && (dy >= -1) && (dy <= 1);
`else
        in_safe = safe_on_board && (x == safe_x) && (y == safe_y);
`endif
        accept = in_range && !occupied && !in_safe;
    end

endmodule

// File: rtl/ms_mine_gen.sv
// Places exactly N_MINES unique mines on a W x H board from one random sample per clock.
// The random input is named rand_xy because rand is a reserved word; MS_SAFE_ZONE_EN selects the 3x3 safe zone.
module ms_mine_gen
    import ms_pkg::*;
#(
    parameter int W       = 8,
    parameter int H       = 8,
    parameter int N_MINES = 10,
    parameter int XW      = $clog2(W),
    parameter int YW      = $clog2(H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [XW-1:0]     safe_x,
    input  logic [YW-1:0]     safe_y,
    input  logic [XW+YW-1:0]  rand_xy,
    output logic [W*H-1:0]    mine,
    output logic              gen_done,
    output logic              busy,
    output logic [REJ_W-1:0]  reject_cnt
);

    localparam int IW = $clog2(W * H);
    localparam int CW = $clog2(N_MINES + 1);

    if (W < 2 || W > 32 || H < 2 || H > 32) begin : g_bad_dim
        $error("ms_mine_gen: W and H must lie in 2..32");
    end
    if (N_MINES < 1 || N_MINES > W * H - 9) begin : g_bad_mines
        $error("ms_mine_gen: N_MINES must lie in 1..W*H-9");
    end

    ms_gen_state_t     state_q, state_d;
    logic [W*H-1:0]    mine_q, mine_d;
    logic [CW-1:0]     count_q, count_d;
    logic [XW-1:0]     safe_x_q, safe_x_d;
    logic [YW-1:0]     safe_y_q, safe_y_d;
    logic [REJ_W-1:0]  rej_q, rej_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
    logic [IW-1:0]     cell_idx;

    ms_coord_filter #(
        .W (W),
        .H (H),
        .XW(XW),
        .YW(YW),
        .IW(IW)
    ) u_filter (
        .rand_xy(rand_xy),
        .safe_x (safe_x_q),
        .safe_y (safe_y_q),
        .mine   (mine_q),
        .accept (accept),
        .idx    (cell_idx)
    );

    // NOTE: every _d starts from its _q so no path through the case leaves a latch.
    always_comb begin
        state_d  = state_q;
        mine_d   = mine_q;
        count_d  = count_q;
        safe_x_d = safe_x_q;
        safe_y_d = safe_y_q;
        rej_d    = rej_q;
        busy_d   = busy_q;
        done_d   = done_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = GEN;
                    safe_x_d = safe_x;
                    safe_y_d = safe_y;
                    mine_d   = '0;
                    count_d  = '0;
                    rej_d    = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                end
            end
            GEN: begin
                if (accept) begin
                    mine_d[cell_idx] = 1'b1;
                    count_d          = count_q + 1'b1;
                    if (count_q == CW'(N_MINES - 1)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else if (rej_q != '1) begin
                    rej_d = rej_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment only; the field is a flop
    // vector (not a RAM), so clearing it in reset is legal and required.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mine_q   <= '0;
            count_q  <= '0;
            safe_x_q <= '0;
            safe_y_q <= '0;
            rej_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mine_q   <= mine_d;
            count_q  <= count_d;
            safe_x_q <= safe_x_d;
            safe_y_q <= safe_y_d;
            rej_q    <= rej_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign mine       = mine_q;
    assign gen_done   = done_q;
    assign busy       = busy_q;
    assign reject_cnt = rej_q;

endmodule

// File: tb/tb_ms_mine_gen.sv
// Self-checking bench for ms_mine_gen: random samples compared every cycle against a board-level model.
module tb_ms_mine_gen;

    localparam int BW = 8;
    localparam int BH = 8;
    localparam int NM = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  safe_x;
    logic [2:0]  safe_y;
    logic [5:0]  rand_xy;
    logic [63:0] mine;
    logic        gen_done;
    logic        busy;
    logic [15:0] reject_cnt;

    logic        s_reset;
    logic        s_start;
    logic [2:0]  s_safe_x;
    logic [2:0]  s_safe_y;
    logic [5:0]  s_rand;
    logic [29:0] s_mine;
    logic        s_gen_done;
    logic        s_busy;
    logic [15:0] s_rej;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ms_mine_gen #(.W(BW), .H(BH), .N_MINES(NM)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .safe_x    (safe_x),
        .safe_y    (safe_y),
        .rand_xy   (rand_xy),
        .mine      (mine),
        .gen_done  (gen_done),
        .busy      (busy),
        .reject_cnt(reject_cnt)
    );

    ms_mine_gen #(.W(6), .H(5), .N_MINES(10)) u_dut_small (
        .clk       (clk),
        .reset     (s_reset),
        .start     (s_start),
        .safe_x    (s_safe_x),
        .safe_y    (s_safe_y),
        .rand_xy   (s_rand),
        .mine      (s_mine),
        .gen_done  (s_gen_done),
        .busy      (s_busy),
        .reject_cnt(s_rej)
    );

    // Reference board: 0 = waiting, 1 = placing mines, 2 = field finished.
    bit [63:0] m_mine;
    int        m_cnt;
    int        m_rej;
    int        m_phase;
    int        m_sx;
    int        m_sy;
    logic [15:0] lfsr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_safe(input int x, input int y);
        if (m_sx < 0 || m_sx >= BW || m_sy < 0 || m_sy >= BH) return 1'b0;
`ifdef MS_SAFE_ZONE_EN
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (x == m_sx + dx && y == m_sy + dy) return 1'b1;
        return 1'b0;
`else
        return (x == m_sx) && (y == m_sy);
`endif
    endfunction

    // One clock: drive inputs, advance the model, then compare all outputs.
    task automatic cycle(input bit rst, input bit st, input int sx, input int sy,
                         input int x, input int y);
        reset   = rst;
        start   = st;
        safe_x  = 3'(sx);
        safe_y  = 3'(sy);
        rand_xy = {3'(y), 3'(x)};
        if (rst) begin
            m_mine = '0; m_cnt = 0; m_rej = 0; m_phase = 0; m_sx = 0; m_sy = 0;
        end else if (st && m_phase != 1) begin
            m_mine = '0; m_cnt = 0; m_rej = 0; m_phase = 1; m_sx = sx; m_sy = sy;
        end else if (m_phase == 1) begin
            if (x < BW && y < BH && !m_mine[y*BW+x] && !is_safe(x, y)) begin
                m_mine[y*BW+x] = 1'b1;
                m_cnt++;
                if (m_cnt == NM) m_phase = 2;
            end else if (m_rej < 65535) begin
                m_rej++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("mine", mine, m_mine);
        check("reject_cnt", 64'(reject_cnt), 64'(m_rej));
        check("busy", 64'(busy), 64'(m_phase == 1));
        check("gen_done", 64'(gen_done), 64'(m_phase == 2));
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Feed samples until the field completes or the cycle budget runs out.
    task automatic run_to_done(input int sx, input int sy, input bit use_lfsr);
        int n;
        logic [5:0] r;
        n = 0;
        while (m_phase == 1 && n < 500) begin
            if (use_lfsr) begin
                lfsr = lfsr_next(lfsr);
                r    = lfsr[5:0];
            end else begin
                r = 6'($urandom);
            end
            cycle(0, 0, sx, sy, int'(r[2:0]), int'(r[5:3]));
            n++;
        end
        check("done_in_budget", 64'(gen_done), 64'(1));
        check("popcount", 64'($countones(mine)), 64'(NM));
    endtask

    int cx[9] = '{5, 7, 2, 6, 0, 4, 7, 3, 1};
    int cy[9] = '{0, 1, 4, 6, 7, 2, 7, 5, 6};

    initial begin
        m_mine = '0; m_cnt = 0; m_rej = 0; m_phase = 0; m_sx = 0; m_sy = 0;
        s_reset = 1'b1; s_start = 1'b0; s_safe_x = '0; s_safe_y = '0; s_rand = '0;

        // Reset held three cycles with start high, then idle without start.
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0);
        s_reset = 1'b0;
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Small board: out-of-range samples rejected, then one in-range accept.
        s_start = 1'b1;
        @(posedge clk); @(negedge clk);
        s_start = 1'b0;
        check("small_busy", 64'(s_busy), 64'(1));
        s_rand = {3'd2, 3'd7};
        @(posedge clk); @(negedge clk);
        s_rand = {3'd6, 3'd1};
        @(posedge clk); @(negedge clk);
        check("small_rej", 64'(s_rej), 64'(2));
        check("small_mine_empty", 64'(s_mine), 64'(0));
        s_rand = {3'd3, 3'd4};
        @(posedge clk); @(negedge clk);
        check("small_accept_idx22", 64'(s_mine), 64'(30'd1 << 22));
        check("small_rej_hold", 64'(s_rej), 64'(2));

        // Duplicate cell rejected, then nine distinct cells complete the field.
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 3, 3);
        cycle(0, 0, 0, 0, 3, 3);
        check("dup_rej_cnt", 64'(reject_cnt), 64'(1));
        check("dup_mine27", 64'(mine[27]), 64'(1));
        for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0, cx[i], cy[i]);
        check("t2_done", 64'(gen_done), 64'(1));
        check("t2_popcount", 64'($countones(mine)), 64'(NM));

        // Diagonal neighbour of the first click.
        cycle(0, 1, 4, 4, 0, 0);
        cycle(0, 0, 4, 4, 5, 5);
`ifdef MS_SAFE_ZONE_EN
        check("zone_mine45", 64'(mine[45]), 64'(0));
`else
        check("zone_mine45", 64'(mine[45]), 64'(1));
`endif
        run_to_done(4, 4, 1'b0);

        // LFSR-driven runs, corner first click, each restarted from DONE.
        for (int s = 0; s < 20; s++) begin
            lfsr = 16'($urandom_range(1, 65535));
            cycle(0, 1, 7, 7, 0, 0);
            run_to_done(7, 7, 1'b1);
            check("corner_safe", 64'(mine[63]), 64'(0));
        end

        // Reset mid-run after four accepts, then a clean run with a stray start.
        begin
            int sx, sy, n;
            sx = $urandom_range(0, 7);
            sy = $urandom_range(0, 7);
            cycle(0, 1, sx, sy, 0, 0);
            n = 0;
            while (m_cnt < 4 && n < 200) begin
                cycle(0, 0, sx, sy, $urandom_range(0, 7), $urandom_range(0, 7));
                n++;
            end
            check("four_accepts", 64'($countones(mine)), 64'(4));
            cycle(1, 0, sx, sy, 0, 0);
            check("midrun_reset_mine", mine, 64'(0));
            cycle(0, 1, 2, 5, 0, 0);
            for (int i = 0; i < 3; i++)
                cycle(0, 0, 2, 5, $urandom_range(0, 7), $urandom_range(0, 7));
            cycle(0, 1, 6, 1, 2, 5);
            run_to_done(2, 5, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
